// File: rtl/cnt_rr_sched_pkg.sv
// Shared types and constants for the round-robin counter scheduler.
package cnt_sched_pkg;

  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_WIDTH = 8;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t ACK  = 2'd2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnt_rr_sched_rr_pick.sv
// Combinational round-robin selector: first asserted req above ptr, modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  int unsigned j;

  // Scan from farthest to nearest so the nearest asserted requester wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      j = (32'(ptr) + k) % NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler sharing one accumulating counter among NREQ requesters.
// Define CNT_SCHED_SAT_EN to saturate at all-ones instead of wrapping.
module cnt_rr_sched
  import cnt_sched_pkg::*;
#(
  parameter  int unsigned NREQ  = DEF_NREQ,
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] inc,
  input  logic                  clr,
  output logic [NREQ-1:0]       ack,
  output logic [IDW-1:0]        grant_id,
  output logic [WIDTH-1:0]      cnt,
  output logic                  busy,
  output logic                  wrap
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] inc_arr [NREQ];
  logic [WIDTH:0]   sum;

  for (genvar i = 0; i < NREQ; i++) begin : g_inc
    assign inc_arr[i] = inc[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign sum = {1'b0, cnt_q} + {1'b0, op_q};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          cnt_d = '0;
        end else if (pick_valid) begin
          gid_d   = pick_idx;
          op_d    = inc_arr[pick_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
`ifdef CNT_SCHED_SAT_EN
        cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        cnt_d = sum[WIDTH-1:0];
`endif
        wrap_d  = sum[WIDTH];
        state_d = ACK;
      end
      ACK: begin
        ptr_d   = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      gid_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[gid_q] = 1'b1;
  end

  assign grant_id = gid_q;
  assign cnt      = cnt_q;
  assign busy     = (state_q == EXEC) || (state_q == ACK);
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_cnt_rr_sched.sv
// Scoreboard bench for cnt_rr_sched: stimulus pushes expected acks, a monitor pops and checks.
module tb_cnt_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] inc = '0;
  logic                  clr = 1'b0;
  logic [NREQ-1:0]       ack;
  logic [1:0]            grant_id;
  logic [WIDTH-1:0]      cnt;
  logic                  busy;
  logic                  wrap;

  typedef struct {
    int id;
    int cnt;
    int wrap;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

`ifdef CNT_SCHED_SAT_EN
  localparam int OVF_CNT = 255;
`else
  localparam int OVF_CNT = 4;
`endif

  cnt_rr_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .inc      (inc),
    .clr      (clr),
    .ack      (ack),
    .grant_id (grant_id),
    .cnt      (cnt),
    .busy     (busy),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc(input int i, input int v);
    inc[i*WIDTH +: WIDTH] = v[WIDTH-1:0];
  endtask

  task automatic push(input int id, input int c, input int w, input int at);
    exp_t e;
    e.id = id; e.cnt = c; e.wrap = w; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (ack != '0) return;
    end
    checks++;
    errors++;
    $display("FAIL ack_timeout actual=none expected=ack within %0d cycles", budget);
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (ack != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=%b expected=none", ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_vec", int'(ack), 1 << e.id);
        chk("grant_id", int'(grant_id), e.id);
        chk("ack_cnt", int'(cnt), e.cnt);
        chk("ack_wrap", int'(wrap), e.wrap);
        chk("ack_cycle", cyc, e.cyc);
        chk("ack_busy", int'(busy), 1);
      end
    end else if (wrap) begin
      chk("wrap_idle", int'(wrap), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // 1: reset state, single request
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_gid", int'(grant_id), 0);
    tick();
    c = cyc;
    req = 4'b0001; set_inc(0, 5);
    push(0, 5, 0, c + 2);
    wait_ack(6);
    req = '0;

    // 2: all requesting, round-robin order from a fresh reset
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    tick();
    c = cyc;
    req = 4'b1111;
    set_inc(0, 1); set_inc(1, 2); set_inc(2, 3); set_inc(3, 4);
    push(0, 1, 0, c + 2);
    push(1, 3, 0, c + 5);
    push(2, 6, 0, c + 8);
    push(3, 10, 0, c + 11);
    push(0, 11, 0, c + 14);
    for (int k = 0; k < 5; k++) wait_ack(6);
    req = '0;

    // 3: clear, then overflow
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", int'(cnt), 0);
    tick();
    c = cyc;
    req = 4'b0100; set_inc(2, 250);
    push(2, 250, 0, c + 2);
    wait_ack(6);
    req = '0;
    tick();
    c = cyc;
    req = 4'b0100; set_inc(2, 10);
    push(2, OVF_CNT, 1, c + 2);
    wait_ack(6);
    req = '0;
    tick(); tick();

    // 4: clr beats req in IDLE; clr in EXEC is ignored
    tick();
    c = cyc;
    clr = 1'b1; req = 4'b0010; set_inc(1, 7);
    push(1, 7, 0, c + 3);
    tick(); clr = 1'b0;
    @(negedge clk);
    chk("clr_prio_cnt", int'(cnt), 0);
    chk("clr_prio_busy", int'(busy), 0);
    tick(); clr = 1'b1;
    @(negedge clk);
    chk("exec_busy", int'(busy), 1);
    tick(); clr = 1'b0; req = '0;
    tick();
    @(negedge clk);
    chk("exec_clr_ignored", int'(cnt), 7);

    // 5: operand latched at grant
    tick();
    c = cyc;
    req = 4'b1000; set_inc(3, 9);
    push(3, 16, 0, c + 2);
    tick(); req = '0; set_inc(3, 100);
    tick(); tick();

    // 6: reset during EXEC aborts; pointer returns to NREQ-1
    tick();
    req = 4'b0001; set_inc(0, 3);
    tick(); rst = 1'b1; req = '0;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("abort_cnt", int'(cnt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ack", int'(ack), 0);
    tick();
    c = cyc;
    req = 4'b1010; set_inc(1, 4); set_inc(3, 6);
    push(1, 4, 0, c + 2);
    push(3, 10, 0, c + 5);
    wait_ack(6);
    req = 4'b1000;
    wait_ack(6);
    req = '0;

    // inc=0 completes a full handshake with no change
    tick();
    c = cyc;
    req = 4'b0100; set_inc(2, 0);
    push(2, 10, 0, c + 2);
    wait_ack(6);
    req = '0;

    repeat (4) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
